// File: rtl/endstop_event_arbiter.sv
// Endstop event arbiter: per-channel pending slots feeding one shared event FIFO
// through a round-robin grant, with sticky per-channel drop flags.
module endstop_event_arbiter #(
  parameter int NCH   = 4,
  parameter int DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCH-1:0]    enable,
  input  logic [NCH-1:0]    ev_changed,
  input  logic [NCH-1:0]    ev_value,
  input  logic [32*NCH-1:0] ev_pos,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        out_chan,
  output logic              out_value,
  output logic [31:0]       out_pos,
  output logic [3:0]        fifo_level,
  output logic [NCH-1:0]    overflow,
  input  logic [NCH-1:0]    overflow_clr
);

  localparam int AW = $clog2(DEPTH);

  logic [NCH-1:0] r_pend_full;
  logic [NCH-1:0] r_pend_val;
  logic [31:0]    r_pend_pos [NCH];
  logic [NCH-1:0] r_ovf;
  logic [2:0]     r_rr;

  logic [2:0]     r_mem_chan [DEPTH];
  logic           r_mem_val  [DEPTH];
  logic [31:0]    r_mem_pos  [DEPTH];
  logic [AW-1:0]  r_wptr;
  logic [AW-1:0]  r_rptr;
  logic [3:0]     r_level;

  logic           w_pop;
  logic           w_can_push;
  logic           w_grant;
  logic [2:0]     w_gnt_idx;
  logic           w_gnt_val;
  logic [31:0]    w_gnt_pos;
  logic [NCH-1:0] w_gnt_vec;
  logic [NCH-1:0] w_new;
  logic [3:0]     w_sum;
  logic [2:0]     w_rr_next;

  // A full FIFO may still accept a push when the head is popped in the same cycle.
  assign w_pop      = (r_level != 4'd0) & out_ready;
  assign w_can_push = (r_level != 4'(DEPTH)) | w_pop;
  assign w_new      = ev_changed & enable;
  assign w_rr_next  = (w_gnt_idx == 3'(NCH-1)) ? 3'd0 : (w_gnt_idx + 3'd1);

  // Round-robin search from r_rr; the first full slot wins.
  always_comb begin
    w_grant   = 1'b0;
    w_gnt_idx = 3'd0;
    w_gnt_val = 1'b0;
    w_gnt_pos = 32'd0;
    w_gnt_vec = '0;
    w_sum     = 4'd0;
    for (int k = 0; k < NCH; k++) begin
      w_sum = {1'b0, r_rr} + 4'(k);
      if (w_sum >= 4'(NCH)) begin
        w_sum = w_sum - 4'(NCH);
      end else begin
        w_sum = w_sum;
      end
      for (int c = 0; c < NCH; c++) begin
        if (!w_grant && w_can_push && r_pend_full[c] && (4'(c) == w_sum)) begin
          w_grant      = 1'b1;
          w_gnt_idx    = 3'(c);
          w_gnt_val    = r_pend_val[c];
          w_gnt_pos    = r_pend_pos[c];
          w_gnt_vec[c] = 1'b1;
        end else begin
          w_grant = w_grant;
        end
      end
    end
  end

  // Pending slots, sticky overflow flags (set beats clear) and round-robin pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend_full <= '0;
      r_pend_val  <= '0;
      r_ovf       <= '0;
      r_rr        <= 3'd0;
      for (int i = 0; i < NCH; i++) r_pend_pos[i] <= 32'd0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (w_new[i] && (!r_pend_full[i] || w_gnt_vec[i])) begin
          r_pend_full[i] <= 1'b1;
          r_pend_val[i]  <= ev_value[i];
          r_pend_pos[i]  <= ev_pos[32*i +: 32];
        end else if (w_gnt_vec[i]) begin
          r_pend_full[i] <= 1'b0;
        end
        r_ovf[i] <= (r_ovf[i] & ~overflow_clr[i]) |
                    (w_new[i] & r_pend_full[i] & ~w_gnt_vec[i]);
      end
      if (w_grant) r_rr <= w_rr_next;
    end
  end

  // Circular event FIFO; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= 4'd0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_chan[i] <= 3'd0;
        r_mem_val[i]  <= 1'b0;
        r_mem_pos[i]  <= 32'd0;
      end
    end else begin
      if (w_grant) begin
        r_mem_chan[r_wptr] <= w_gnt_idx;
        r_mem_val[r_wptr]  <= w_gnt_val;
        r_mem_pos[r_wptr]  <= w_gnt_pos;
        r_wptr             <= r_wptr + AW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      case ({w_grant, w_pop})
        2'b10:   r_level <= r_level + 4'd1;
        2'b01:   r_level <= r_level - 4'd1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign out_valid  = (r_level != 4'd0);
  assign out_chan   = out_valid ? r_mem_chan[r_rptr] : 3'd0;
  assign out_value  = out_valid ? r_mem_val[r_rptr]  : 1'b0;
  assign out_pos    = out_valid ? r_mem_pos[r_rptr]  : 32'd0;
  assign fifo_level = r_level;
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_endstop_event_arbiter.sv
// Randomized + directed bench: a queue-based reference model predicts the event stream,
// a negedge monitor compares every presented head against the scoreboard.
module tb_endstop_event_arbiter;
  localparam int NCH = 4, DEPTH = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic [NCH-1:0] enable, ev_changed, ev_value, overflow, overflow_clr;
  logic [32*NCH-1:0] ev_pos;
  logic out_valid, out_ready, out_value;
  logic [2:0] out_chan;
  logic [31:0] out_pos;
  logic [3:0] fifo_level;

  endstop_event_arbiter #(.NCH(NCH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .enable(enable), .ev_changed(ev_changed),
    .ev_value(ev_value), .ev_pos(ev_pos), .out_valid(out_valid), .out_ready(out_ready),
    .out_chan(out_chan), .out_value(out_value), .out_pos(out_pos),
    .fifo_level(fifo_level), .overflow(overflow), .overflow_clr(overflow_clr));

  typedef struct packed { logic [2:0] chan; logic val; logic [31:0] pos; } ev_t;
  ev_t exp_q[$];

  // reference model state
  bit          m_full[NCH];
  bit          m_val[NCH];
  logic [31:0] m_pos[NCH];
  int          m_rr, m_level;
  logic [NCH-1:0] m_ovf;

  int n_pass = 0, n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, want);
  endtask

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < NCH; i++) begin m_full[i] = 0; m_val[i] = 0; m_pos[i] = 0; end
    m_rr = 0; m_level = 0; m_ovf = '0;
  endtask

  // One clock edge of the rules: pop, pick a winner from rr onward, then capture pulses.
  task automatic model_step();
    bit pop, can, set;
    int g;
    ev_t e;
    if (!reset) begin model_reset(); return; end
    pop = (m_level > 0) && out_ready;
    can = (m_level < DEPTH) || pop;
    g = -1;
    if (can)
      for (int k = 0; k < NCH; k++)
        if (g < 0 && m_full[(m_rr + k) % NCH]) g = (m_rr + k) % NCH;
    if (g >= 0) begin
      e.chan = 3'(g); e.val = m_val[g]; e.pos = m_pos[g];
      exp_q.push_back(e);
      m_full[g] = 0;
      m_rr = (g + 1) % NCH;
    end
    for (int i = 0; i < NCH; i++) begin
      set = 0;
      if (ev_changed[i] && enable[i]) begin
        if (m_full[i]) set = 1;
        else begin m_full[i] = 1; m_val[i] = ev_value[i]; m_pos[i] = ev_pos[32*i +: 32]; end
      end
      m_ovf[i] = (m_ovf[i] & ~overflow_clr[i]) | set;
    end
    m_level = m_level + ((g >= 0) ? 1 : 0) - (pop ? 1 : 0);
  endtask

  // monitor: compare the presented head with the scoreboard, pop on handshake
  always @(negedge clk) begin
    chk("fifo_level", 64'(fifo_level), 64'(m_level));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    if (out_valid) begin
      if (exp_q.size() == 0) chk("spurious_valid", 64'(out_valid), 64'd0);
      else begin
        chk("out_chan", 64'(out_chan), 64'(exp_q[0].chan));
        chk("out_value", 64'(out_value), 64'(exp_q[0].val));
        chk("out_pos", 64'(out_pos), 64'(exp_q[0].pos));
        if (out_ready) void'(exp_q.pop_front());
      end
    end else begin
      chk("idle_fields", 64'({out_chan, out_value, out_pos}), 64'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    ev_changed   = '0;
    overflow_clr = '0;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse(input int ch, input bit v, input logic [31:0] p);
    ev_changed[ch] = 1'b1;
    ev_value[ch]   = v;
    ev_pos[32*ch +: 32] = p;
  endtask

  initial begin
    reset = 1'b0; enable = '1; ev_changed = '0; ev_value = '0; ev_pos = '0;
    out_ready = 1'b0; overflow_clr = '0;
    model_reset();

    // reset held: pulses must be ignored
    repeat (2) begin ev_changed = '1; tick(); end
    reset = 1'b1;
    tick();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);

    // two-clock latency
    out_ready = 1'b1;
    pulse(2, 1'b1, 32'h100);
    tick();
    chk("lat_t1_valid", 64'(out_valid), 64'd0);
    tick();
    chk("lat_t2_valid", 64'(out_valid), 64'd1);
    chk("lat_t2_chan", 64'(out_chan), 64'd2);
    chk("lat_t2_pos", 64'(out_pos), 64'h100);
    run(3);

    // round robin, twice
    repeat (2) begin
      for (int c = 0; c < NCH; c++) pulse(c, c[0], 32'(10 * (c + 1)));
      run(7);
    end

    // back-pressure: 12 events, FIFO saturates at 8
    out_ready = 1'b0;
    for (int n = 0; n < 12; n++) begin pulse(n % NCH, n[1], 32'h200 + 32'(n)); run(3); end
    chk("bp_level_sat", 64'(fifo_level), 64'd8);
    out_ready = 1'b1;
    run(20);
    chk("bp_no_ovf", 64'(overflow), 64'd0);
    chk("bp_drained", 64'(fifo_level), 64'd0);

    // overflow on a full FIFO
    out_ready = 1'b0;
    for (int n = 0; n < DEPTH; n++) begin pulse(0, 1'b0, 32'h300 + 32'(n)); run(2); end
    pulse(1, 1'b0, 32'd5); run(2);
    pulse(1, 1'b1, 32'd6); run(2);
    chk("ovf_set", 64'(overflow[1]), 64'd1);
    overflow_clr[1] = 1'b1; tick();
    chk("ovf_clr", 64'(overflow[1]), 64'd0);
    pulse(1, 1'b1, 32'd9); overflow_clr[1] = 1'b1; tick();
    chk("ovf_set_wins", 64'(overflow[1]), 64'd1);
    out_ready = 1'b1; tick();
    chk("push_pop_full", 64'(fifo_level), 64'd8);
    run(12);
    overflow_clr = '1; tick();

    // grant and new pulse on the same channel in the same cycle
    pulse(0, 1'b0, 32'd3); tick();
    pulse(0, 1'b1, 32'd7); tick();
    run(5);
    chk("reload_no_ovf", 64'(overflow[0]), 64'd0);

    // asynchronous reset with queued events
    out_ready = 1'b0;
    for (int n = 0; n < 5; n++) begin pulse(n % NCH, 1'b1, 32'h400 + 32'(n)); run(2); end
    chk("pre_rst_level", 64'(fifo_level), 64'd5);
    #2 reset = 1'b0;
    model_reset();
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_level", 64'(fifo_level), 64'd0);
    tick();
    reset = 1'b1;
    out_ready = 1'b1;
    run(4);
    chk("post_rst_valid", 64'(out_valid), 64'd0);

    // disabled channel
    enable[3] = 1'b0;
    pulse(3, 1'b1, 32'h33);
    run(4);
    chk("disabled_ch", 64'(out_valid), 64'd0);
    enable = '1;

    // randomized traffic
    repeat (400) begin
      enable       = ($urandom_range(0, 9) == 0) ? NCH'($urandom) : '1;
      ev_changed   = NCH'($urandom) & NCH'($urandom);
      ev_value     = NCH'($urandom);
      for (int c = 0; c < NCH; c++) ev_pos[32*c +: 32] = $urandom;
      out_ready    = ($urandom_range(0, 2) != 0);
      overflow_clr = ($urandom_range(0, 7) == 0) ? NCH'($urandom) : '0;
      tick();
    end
    out_ready = 1'b1;
    run(30);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
